eof_intermission_tracker: RTL and testbench
===========================================

# eof_intermission_tracker

Tracks the frame tail of the CAN protocol controller: End-of-Frame (7 recessive bits), Intermission (3 bits) and, optionally, Suspend Transmission (8 bits). It sits directly upstream of the message validator and drives that block's `eof_in_progress`, `eof_bit_count` and `error_detected` inputs (via `form_error`). It flags form errors and overload conditions to the error/overload frame logic and reports bus-idle to the transmit scheduler.

## Interface
- `EOF_LEN`, default 7: EOF field length in bits.
- `INTERMISSION_LEN`, default 3: Intermission field length in bits.
- `SUSPEND_LEN`, default 8: Suspend Transmission length in bits; used only with `SUSPEND_TX_EN`.
- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  low = synchronous clear to reset state.
- `sample_point`  in  1  one-cycle strobe at each bit's sample point.
- `rx_bit`  in  1  sampled bus level; 1 = recessive; valid when `sample_point` = 1.
- `ack_delim_done`  in  1  asserted with `sample_point` on the ACK delimiter sample.
- `is_transmitter`  in  1  node is transmitting the current frame.
- `error_passive`  in  1  node is error-passive.
- `eof_in_progress`  out  1  high while in state EOF.
- `eof_bit_count`  out  3  index 1..7 of the EOF bit at the next sample point; 0 outside EOF.
- `intermission_active`  out  1  high while in state INTERMISSION.
- `suspend_active`  out  1  high while in state SUSPEND; constant 0 without the macro.
- `form_error`  out  1  one-cycle pulse.
- `overload_request`  out  1  one-cycle pulse.
- `sof_detected`  out  1  one-cycle pulse; dominant bit at the 3rd intermission bit.
- `bus_idle`  out  1  level; high in state IDLE.

## Operation
- States: IDLE, EOF, INTERMISSION, SUSPEND. Reset and `enable` = 0 both give:
  - IDLE, all counters 0.
  - `bus_idle` = 1.
  - All other outputs 0.
- State changes happen only on cycles where `sample_point` = 1. `ack_delim_done` without `sample_point` is ignored.
- **Any state, `ack_delim_done` = 1:**
  - Go to EOF with `eof_bit_count` = 1.
  - This takes priority over every other transition.
- **EOF, recessive at bit n < 7:** `eof_bit_count` becomes n + 1.
- **EOF, dominant at bit 1..6:**
  - Pulse `form_error`.
  - Go to IDLE, `eof_bit_count` = 0.
- **EOF, bit 7:** go to INTERMISSION, `eof_bit_count` = 0, intermission count = 1. In addition:
  - Dominant and `is_transmitter` = 1: pulse `form_error`, go to IDLE instead of INTERMISSION.
  - Dominant and not transmitter: pulse `overload_request`; still go to INTERMISSION.
- **INTERMISSION, dominant at bit 1 or 2:**
  - Pulse `overload_request`.
  - Go to IDLE.
- **INTERMISSION, dominant at bit 3:**
  - Pulse `sof_detected`.
  - Go to IDLE.
- **INTERMISSION, recessive at bit 3:**
  - Go to SUSPEND if the macro is enabled, `is_transmitter` = 1 and `error_passive` = 1.
  - Otherwise go to IDLE.
- **SUSPEND:**
  - Count 8 recessive bits, then go to IDLE.
  - A dominant bit gives a `sof_detected` pulse and goes to IDLE.
- **IDLE:** no counting.
- Counter widths:
  - Counters hold 1..field length and saturate.
  - They never wrap.
  - `eof_bit_count` never shows 7 outside EOF, so the validator's completion strobe cannot fire spuriously.

## Timing
- All outputs are registered. State, counters and pulses update one cycle after the qualifying `sample_point` cycle.
- Pulses last exactly one cycle.
- At a bit-7 `sample_point`, `eof_bit_count` = 7 and `eof_in_progress` = 1 are already valid combinationally. The validator therefore sees 7 on that strobe.
- `eof_in_progress` drops one cycle later.
- Latency from the ACK delimiter sample to `eof_in_progress` = 1 is 1 cycle.
- `reset` mid-frame clears immediately (asynchronous). `enable` low clears on the next edge.

## Configuration
- Macro: `SUSPEND_TX_EN`.
- Defined: SUSPEND state is present. An error-passive transmitter waits 8 extra recessive bits after intermission before `bus_idle`.
- Undefined: the SUSPEND state and its counter are not compiled in. `suspend_active` is tied to 0, and intermission bit 3 recessive always goes to IDLE.

## Structure
- Shared package `can_pkg` holds:
  - `frame_tail_state_t` enum (IDLE, EOF, INTERMISSION, SUSPEND).
  - Constants `CAN_EOF_LEN` = 7, `CAN_INTERMISSION_LEN` = 3, `CAN_SUSPEND_LEN` = 8.
- One sub-module: `field_bit_counter`.
  - Parameterised saturating 1..N counter with load, advance-on-strobe, clear and a `last` flag.
  - Instantiated once per field.

## Test plan
- ACK delimiter, then 7 recessive bits, then 3 recessive bits:
  - `eof_bit_count` runs 1..7.
  - `intermission_active` is high for 3 bits.
  - `bus_idle` = 1 after the 3rd intermission bit.
  - No pulses.
- Dominant at EOF bit 4:
  - `form_error` pulses once.
  - `eof_bit_count` = 0.
  - State is IDLE.
- Dominant at EOF bit 7: receiver gives an `overload_request` pulse and goes to INTERMISSION; transmitter gives a `form_error` pulse and goes to IDLE.
- Intermission bits: dominant at bit 2 gives an `overload_request` pulse; dominant at bit 3 gives a `sof_detected` pulse, with no overload.
- Macro defined, transmitter, error-passive: `suspend_active` is high for 8 bits, then `bus_idle` = 1. With the macro undefined, `bus_idle` = 1 right after intermission.
- Reset and enable:
  - `reset` asserted at EOF bit 5: all outputs go to reset values asynchronously.
  - `enable` = 0 at EOF bit 3: all outputs are cleared on the next edge.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN frame-tail types and field lengths.
// Imported by the EOF/intermission tracker and its counters.
package can_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EOF,
      INTERMISSION,
      SUSPEND
   } frame_tail_state_t;

   localparam int CAN_EOF_LEN          = 7;
   localparam int CAN_INTERMISSION_LEN = 3;
   localparam int CAN_SUSPEND_LEN      = 8;

endpackage

// File: rtl/field_bit_counter.sv
// Saturating 1..N bit-index counter for one frame-tail field.
// Priority: clear, then load (to 1), then advance.
module field_bit_counter #(
   parameter int N = 7,
   parameter int W = $clog2(N + 1)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         advance,
   output logic [W-1:0] count,
   output logic         last
);

   assign last = (count == W'(N));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (load)
         count <= W'(1);
      else if (advance && !last)
         count <= count + W'(1);
   end

endmodule

// File: rtl/eof_intermission_tracker.sv
// CAN frame tail tracker: EOF, intermission and optional suspend.
// Define SUSPEND_TX_EN to build the suspend-transmission state.
module eof_intermission_tracker
   import can_pkg::*;
#(
   parameter int EOF_LEN          = CAN_EOF_LEN,
   parameter int INTERMISSION_LEN = CAN_INTERMISSION_LEN,
   parameter int SUSPEND_LEN      = CAN_SUSPEND_LEN
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       sample_point,
   input  logic       rx_bit,
   input  logic       ack_delim_done,
   input  logic       is_transmitter,
   input  logic       error_passive,
   output logic       eof_in_progress,
   output logic [2:0] eof_bit_count,
   output logic       intermission_active,
   output logic       suspend_active,
   output logic       form_error,
   output logic       overload_request,
   output logic       sof_detected,
   output logic       bus_idle
);

   localparam int EW = $clog2(EOF_LEN + 1);
   localparam int IW = $clog2(INTERMISSION_LEN + 1);

   frame_tail_state_t state;

   logic sp, ack, in_eof, in_im, in_sus, go_sus;
   logic eof_clr, eof_adv, eof_last;
   logic im_clr, im_load, im_adv, im_last;
   logic [EW-1:0] eof_cnt;
   logic [IW-1:0] im_cnt;

   assign sp     = enable & sample_point;
   assign ack    = sp & ack_delim_done;
   assign in_eof = (state == EOF);
   assign in_im  = (state == INTERMISSION);
   assign in_sus = (state == SUSPEND);

   // Counters are cleared on every exit so the index reads 0 outside its field
   assign eof_adv = sp & ~ack & in_eof & rx_bit & ~eof_last;
   assign eof_clr = ~enable
                  | (sp & ~ack & in_eof & (~rx_bit | eof_last));

   assign im_load = sp & ~ack & in_eof & eof_last
                  & (rx_bit | ~is_transmitter);
   assign im_adv  = sp & ~ack & in_im & rx_bit & ~im_last;
   assign im_clr  = ~enable | ack
                  | (sp & in_im & (~rx_bit | im_last));

   field_bit_counter #(.N(EOF_LEN), .W(EW)) u_eof_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear   (eof_clr),
      .load    (ack),
      .advance (eof_adv),
      .count   (eof_cnt),
      .last    (eof_last)
   );

   field_bit_counter #(.N(INTERMISSION_LEN), .W(IW)) u_im_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear   (im_clr),
      .load    (im_load),
      .advance (im_adv),
      .count   (im_cnt),
      .last    (im_last)
   );

`ifdef SUSPEND_TX_EN
   localparam int SW = $clog2(SUSPEND_LEN + 1);

   logic sus_clr, sus_adv, sus_last;
   logic [SW-1:0] sus_cnt;

   assign go_sus  = is_transmitter & error_passive;
   assign sus_adv = sp & ~ack & in_sus & rx_bit & ~sus_last;
   assign sus_clr = ~enable | ack
                  | (sp & in_sus & (~rx_bit | sus_last));

   field_bit_counter #(.N(SUSPEND_LEN), .W(SW)) u_sus_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear   (sus_clr),
      .load    (sp & ~ack & in_im & im_last & rx_bit & go_sus),
      .advance (sus_adv),
      .count   (sus_cnt),
      .last    (sus_last)
   );

   assign suspend_active = in_sus;

   logic unused_sig;
   assign unused_sig = ^{im_cnt, sus_cnt};
`else
   assign go_sus         = 1'b0;
   assign suspend_active = 1'b0;

   logic unused_sig;
   assign unused_sig = ^{im_cnt, error_passive, in_sus};
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         form_error       <= 1'b0;
         overload_request <= 1'b0;
         sof_detected     <= 1'b0;
      end else begin
         form_error       <= 1'b0;
         overload_request <= 1'b0;
         sof_detected     <= 1'b0;
         if (!enable) begin
            state <= IDLE;
         end else if (ack) begin
            state <= EOF;
         end else if (sample_point) begin
            case (state)
               EOF: begin
                  if (eof_last) begin
                     if (!rx_bit && is_transmitter) begin
                        form_error <= 1'b1;
                        state      <= IDLE;
                     end else begin
                        overload_request <= ~rx_bit;
                        state            <= INTERMISSION;
                     end
                  end else if (!rx_bit) begin
                     form_error <= 1'b1;
                     state      <= IDLE;
                  end
               end
               INTERMISSION: begin
                  if (!rx_bit) begin
                     if (im_last)
                        sof_detected <= 1'b1;
                     else
                        overload_request <= 1'b1;
                     state <= IDLE;
                  end else if (im_last) begin
                     state <= go_sus ? SUSPEND : IDLE;
                  end
               end
`ifdef SUSPEND_TX_EN
               SUSPEND: begin
                  if (!rx_bit) begin
                     sof_detected <= 1'b1;
                     state        <= IDLE;
                  end else if (sus_last) begin
                     state <= IDLE;
                  end
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign eof_in_progress     = in_eof;
   assign eof_bit_count       = 3'(eof_cnt);
   assign intermission_active = in_im;
   assign bus_idle            = (state == IDLE);

endmodule

// File: tb/tb_eof_intermission_tracker.sv
// Directed bench for the CAN frame tail tracker.
// Expected output vectors are hand-derived per step.
module tb_eof_intermission_tracker;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       sample_point = 1'b0;
   logic       rx_bit = 1'b1;
   logic       ack_delim_done = 1'b0;
   logic       is_transmitter = 1'b0;
   logic       error_passive = 1'b0;
   logic       eof_in_progress;
   logic [2:0] eof_bit_count;
   logic       intermission_active;
   logic       suspend_active;
   logic       form_error;
   logic       overload_request;
   logic       sof_detected;
   logic       bus_idle;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   eof_intermission_tracker dut (
      .clock               (clock),
      .reset               (reset),
      .enable              (enable),
      .sample_point        (sample_point),
      .rx_bit              (rx_bit),
      .ack_delim_done      (ack_delim_done),
      .is_transmitter      (is_transmitter),
      .error_passive       (error_passive),
      .eof_in_progress     (eof_in_progress),
      .eof_bit_count       (eof_bit_count),
      .intermission_active (intermission_active),
      .suspend_active      (suspend_active),
      .form_error          (form_error),
      .overload_request    (overload_request),
      .sof_detected        (sof_detected),
      .bus_idle            (bus_idle)
   );

   // {eof, cnt[2:0], im, sus, fe, ovl, sof, idle}
   function automatic logic [9:0] ev(
      input logic eof, input logic [2:0] cnt, input logic im,
      input logic sus, input logic fe, input logic ovl,
      input logic sof, input logic idle);
      return {eof, cnt, im, sus, fe, ovl, sof, idle};
   endfunction

   task automatic chk(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {eof_in_progress, eof_bit_count, intermission_active,
             suspend_active, form_error, overload_request,
             sof_detected, bus_idle};
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic step(input logic rx, input logic ack_in);
      @(negedge clock);
      sample_point   = 1'b1;
      rx_bit         = rx;
      ack_delim_done = ack_in;
      @(posedge clock);
      #1;
      sample_point   = 1'b0;
      ack_delim_done = 1'b0;
      rx_bit         = 1'b1;
   endtask

   task automatic gap();
      @(posedge clock);
      #1;
   endtask

   localparam logic [9:0] IDLE_V = 10'b0000_000001;

   initial begin
      #1;
      chk("reset_async", IDLE_V);
      @(negedge clock);
      reset = 1'b0;
      gap();
      chk("reset_state", IDLE_V);

      // ack delimiter without sample point is ignored
      @(negedge clock);
      ack_delim_done = 1'b1;
      gap();
      ack_delim_done = 1'b0;
      chk("ack_no_sp", IDLE_V);

      // clean frame tail
      step(1'b1, 1'b1);
      chk("ack_to_eof", ev(1, 3'd1, 0, 0, 0, 0, 0, 0));
      for (int i = 2; i <= 7; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("eof_cnt_%0d", i),
             ev(1, 3'(i), 0, 0, 0, 0, 0, 0));
      end
      step(1'b1, 1'b0);
      chk("eof7_to_im", ev(0, 3'd0, 1, 0, 0, 0, 0, 0));
      step(1'b1, 1'b0);
      chk("im_bit1", ev(0, 3'd0, 1, 0, 0, 0, 0, 0));
      step(1'b1, 1'b0);
      chk("im_bit2", ev(0, 3'd0, 1, 0, 0, 0, 0, 0));
      step(1'b1, 1'b0);
      chk("im_done_idle", IDLE_V);

      // dominant at EOF bit 4
      step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      chk("eof_at4", ev(1, 3'd4, 0, 0, 0, 0, 0, 0));
      step(1'b0, 1'b0);
      chk("eof4_form_err", ev(0, 3'd0, 0, 0, 1, 0, 0, 1));
      gap();
      chk("form_err_1cyc", IDLE_V);

      // dominant at EOF bit 7, receiver
      step(1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("eof7_rx_ovl", ev(0, 3'd0, 1, 0, 0, 1, 0, 0));
      gap();
      chk("ovl_1cyc", ev(0, 3'd0, 1, 0, 0, 0, 0, 0));
      repeat (3) step(1'b1, 1'b0);
      chk("eof7_rx_idle", IDLE_V);

      // dominant at EOF bit 7, transmitter
      is_transmitter = 1'b1;
      step(1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("eof7_tx_ferr", ev(0, 3'd0, 0, 0, 1, 0, 0, 1));
      is_transmitter = 1'b0;

      // dominant at intermission bit 2
      step(1'b1, 1'b1);
      repeat (7) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("im2_ovl", ev(0, 3'd0, 0, 0, 0, 1, 0, 1));

      // dominant at intermission bit 3
      step(1'b1, 1'b1);
      repeat (7) step(1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("im3_sof", ev(0, 3'd0, 0, 0, 0, 0, 1, 1));
      gap();
      chk("sof_1cyc", IDLE_V);

      // error-passive transmitter after intermission
      is_transmitter = 1'b1;
      error_passive  = 1'b1;
      step(1'b1, 1'b1);
      repeat (7) step(1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0);
`ifdef SUSPEND_TX_EN
      chk("sus_enter", ev(0, 3'd0, 0, 1, 0, 0, 0, 0));
      repeat (7) step(1'b1, 1'b0);
      chk("sus_bit8", ev(0, 3'd0, 0, 1, 0, 0, 0, 0));
      step(1'b1, 1'b0);
      chk("sus_done", IDLE_V);
`else
      chk("no_sus_idle", IDLE_V);
`endif
      is_transmitter = 1'b0;
      error_passive  = 1'b0;

      // asynchronous reset at EOF bit 5
      step(1'b1, 1'b1);
      repeat (4) step(1'b1, 1'b0);
      chk("eof_at5", ev(1, 3'd5, 0, 0, 0, 0, 0, 0));
      #2;
      reset = 1'b1;
      #1;
      chk("reset_mid", IDLE_V);
      @(negedge clock);
      reset = 1'b0;

      // enable low at EOF bit 3
      step(1'b1, 1'b1);
      repeat (2) step(1'b1, 1'b0);
      @(negedge clock);
      enable = 1'b0;
      #1;
      chk("en_low_hold", ev(1, 3'd3, 0, 0, 0, 0, 0, 0));
      gap();
      chk("en_low_clear", IDLE_V);
      @(negedge clock);
      enable = 1'b1;

      // recovery after enable
      step(1'b1, 1'b1);
      chk("recover_eof", ev(1, 3'd1, 0, 0, 0, 0, 0, 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
